demultiplexer1x2_buffered: RTL and testbench
============================================

// Module: demultiplexer1x2_buffered
// PURPOSE
//  1-to-2 stream demultiplexer with per-output buffering: the inverse of the datapath 2x1 mux.
//  Takes one valid/ready input stream plus a select bit. Steers each word into one of two
//  FIFOs (a/b). Sits between the core load/store path and its two targets: data memory (a)
//  and MMIO (b). A stalled target backpressures only its own words.
// PARAMETERS
//  WIDTH   32  data word width in bits
//  DEPTH   2   entries per output FIFO; power of two, >=2
//  CNT_W   16  width of transfer counters (used only with DEMUX_STATS_EN)
// PORTS
//  clk        in   1      single clock, all state on rising edge
//  rst        in   1      synchronous reset, active-high
//  in_valid   in   1      input word present
//  in_ready   out  1      block accepts input word this cycle
//  in_sel     in   1      0 -> output a, 1 -> output b
//  in_data    in   WIDTH  input word
//  a_valid    out  1      output a head valid
//  a_ready    in   1      sink a accepts head
//  a_data     out  WIDTH  output a head word
//  b_valid    out  1      output b head valid
//  b_ready    in   1      sink b accepts head
//  b_data     out  WIDTH  output b head word
//  a_count    out  CNT_W  words popped on a (present only with DEMUX_STATS_EN)
//  b_count    out  CNT_W  words popped on b (present only with DEMUX_STATS_EN)
// BEHAVIOUR
//  - Reset: all FIFOs empty. a_valid=b_valid=0, a_data=b_data=0, in_ready=1, counters=0.
//    Reset mid-stream discards all buffered words. Reset overrides push/pop in that cycle.
//  - in_ready = !full[in_sel]. Combinational in in_sel and FIFO state only, never in a_ready/b_ready.
//  - Push: in_valid & in_ready writes in_data into FIFO[in_sel] at the rising edge.
//  - Pop: x_valid & x_ready removes the head of FIFO x at the rising edge.
//  - Latency: a word pushed into an empty FIFO appears on x_valid/x_data the next cycle.
//    There is no same-cycle pass-through.
//  - x_valid = !empty_x. x_data = head entry when valid, forced to 0 when not valid.
//  - Push and pop on the same FIFO in the same cycle: both take effect and occupancy is unchanged.
//    Valid in any non-full state. When full, push is blocked by in_ready=0 even if a pop occurs.
//  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Occupancy counter is log2(DEPTH)+1 bits.
//    full = (occ==DEPTH), empty = (occ==0).
//  - Order is preserved per output. No ordering is guaranteed between a and b.
//  - Source protocol: once in_valid=1 and in_ready=0, the source holds in_sel and in_data stable.
//    The block does not check this rule.
//  - A full FIFO a never blocks a word with in_sel=1, and vice versa.
// CONFIGURATION
//  - DEMUX_STATS_EN defined: a_count/b_count ports exist. Each increments by 1 per pop on its
//    output and saturates at 2^CNT_W-1, with no wrap.
//  - DEMUX_STATS_EN undefined: no counter ports and no counter logic. Datapath is otherwise identical.
// STRUCTURE
//  - Shared package demux_pkg: localparam SEL_A=1'b0, SEL_B=1'b1, and the pointer-width
//    function clog2 used for DEPTH.
//  - Sub-module stream_fifo (WIDTH, DEPTH): push/pop/full/empty/head. Instantiated twice, for a and b.
//  - Top level holds the select steering, in_ready mux, output zero-gating and optional counters.
// TESTING
//  1. Reset: assert rst 2 cycles with in_valid=1 -> a_valid=b_valid=0, data=0, in_ready=1, no push.
//  2. Routing: push 32'hAAAAAAAA sel=0, then 32'hBBBBBBBB sel=1, sinks ready -> each word
//     appears only on its output, 1 cycle after its push.
//  3. Backpressure isolation: a_ready=0, push 3 words sel=0 -> in_ready=0 after 2 words.
//     A sel=1 word is still accepted. Release a_ready -> both words drain in order.
//  4. Full push+pop: FIFO a full, a_ready=1, in_valid=1 sel=0 -> pop occurs, push refused that cycle.
//     The next cycle accepts the push. Order is kept across pointer wrap.
//  5. Mid-stream reset: 2 words buffered in a, 1 in b, rst for 1 cycle -> all valids 0 next cycle.
//     Buffered words are never emitted.
//  6. DEMUX_STATS_EN with CNT_W=2: 5 pops on a -> a_count=3 (saturated), b_count=0.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared constants for the buffered 1x2 stream demultiplexer.
// Select encodings and the constant-function log2 used to size FIFO pointers.
package demux_pkg;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((64'd1 << res) < 64'(value)) begin
      res = res + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/stream_fifo.sv
// Synchronous FIFO with wrapping pointers and an occupancy counter.
// Caller must not push when full nor pop when empty.
module stream_fifo
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned PTR_W = clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [PTR_W:0]   occ_q, occ_d;

  always_comb begin
    occ_d = occ_q;
    unique case ({push, pop})
      2'b10:   occ_d = occ_q + (PTR_W+1)'(1);
      2'b01:   occ_d = occ_q - (PTR_W+1)'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PTR_W'(1);
      if (pop)  rptr_q <= rptr_q + PTR_W'(1);
      occ_q <= occ_d;
    end
  end

  // Storage needs no reset: head is gated by empty at the top level.
  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wptr_q] <= wdata;
  end

  assign full  = (occ_q == (PTR_W+1)'(DEPTH));
  assign empty = (occ_q == '0);
  assign head  = mem_q[rptr_q];

endmodule

// File: rtl/demultiplexer1x2_buffered.sv
// 1-to-2 stream demultiplexer with one FIFO per output; a stalled sink only blocks its own words.
// Define DEMUX_STATS_EN to add saturating per-output pop counters (a_count/b_count).
module demultiplexer1x2_buffered
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
`ifdef DEMUX_STATS_EN
  , parameter int unsigned CNT_W = 16
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [WIDTH-1:0] b_data
`ifdef DEMUX_STATS_EN
  , output logic [CNT_W-1:0] a_count,
  output logic [CNT_W-1:0]   b_count
`endif
);

  logic             full_a, empty_a, push_a, pop_a;
  logic             full_b, empty_b, push_b, pop_b;
  logic [WIDTH-1:0] head_a, head_b;

  // Ready depends only on the selected FIFO, never on sink readiness.
  assign in_ready = (in_sel == SEL_B) ? !full_b : !full_a;
  assign push_a   = in_valid && in_ready && (in_sel == SEL_A);
  assign push_b   = in_valid && in_ready && (in_sel == SEL_B);
  assign pop_a    = a_valid && a_ready;
  assign pop_b    = b_valid && b_ready;

  assign a_valid = !empty_a;
  assign b_valid = !empty_b;
  assign a_data  = a_valid ? head_a : '0;
  assign b_data  = b_valid ? head_b : '0;

  stream_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo_a (
    .clk   (clk),
    .rst   (rst),
    .push  (push_a),
    .pop   (pop_a),
    .wdata (in_data),
    .full  (full_a),
    .empty (empty_a),
    .head  (head_a)
  );

  stream_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo_b (
    .clk   (clk),
    .rst   (rst),
    .push  (push_b),
    .pop   (pop_b),
    .wdata (in_data),
    .full  (full_b),
    .empty (empty_b),
    .head  (head_b)
  );

`ifdef DEMUX_STATS_EN
  logic [CNT_W-1:0] a_count_q, b_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_count_q <= '0;
      b_count_q <= '0;
    end else begin
      if (pop_a && (a_count_q != '1)) a_count_q <= a_count_q + CNT_W'(1);
      if (pop_b && (b_count_q != '1)) b_count_q <= b_count_q + CNT_W'(1);
    end
  end

  assign a_count = a_count_q;
  assign b_count = b_count_q;
`endif

endmodule

// File: tb/tb_demultiplexer1x2_buffered.sv
// Bench for demultiplexer1x2_buffered: vector table, per-output queue scoreboard, random stress.
// Counter checks are compiled in when DEMUX_STATS_EN is defined.
module tb_demultiplexer1x2_buffered;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 2;
`ifdef DEMUX_STATS_EN
  localparam int unsigned CNT_W = 2;
`endif

  logic             clk;
  logic             rst;
  logic             in_valid, in_ready, in_sel;
  logic [WIDTH-1:0] in_data;
  logic             a_valid, a_ready, b_valid, b_ready;
  logic [WIDTH-1:0] a_data, b_data;
`ifdef DEMUX_STATS_EN
  logic [CNT_W-1:0] a_count, b_count;
`endif

  demultiplexer1x2_buffered #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
`ifdef DEMUX_STATS_EN
    , .CNT_W (CNT_W)
`endif
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sel   (in_sel),
    .in_data  (in_data),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .a_data   (a_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .b_data   (b_data)
`ifdef DEMUX_STATS_EN
    , .a_count (a_count),
    .b_count  (b_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic        v;
    logic        sel;
    logic [31:0] data;
    logic        ar;
    logic        br;
    logic        chk;
    logic        ir;
    logic        av;
    logic        bv;
  } vec_t;

  localparam int NVEC = 26;
  vec_t tbl [NVEC];

  logic [WIDTH-1:0] qa[$];
  logic [WIDTH-1:0] qb[$];
  int errors = 0;
  int checks = 0;
  bit model_ok = 0;
  int unsigned cnt_a = 0;
  int unsigned cnt_b = 0;

  function automatic vec_t mk(input logic r, v, s, input logic [31:0] d, input logic ar, br,
                              input logic c, ir, av, bv);
    vec_t t;
    t.rst = r; t.v = v; t.sel = s; t.data = d; t.ar = ar; t.br = br;
    t.chk = c; t.ir = ir; t.av = av; t.bv = bv;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, v, s, input logic [31:0] d, input logic ar, br);
    rst = r; in_valid = v; in_sel = s; in_data = d; a_ready = ar; b_ready = br;
  endtask

  // Called at a falling edge with inputs already applied; advances to the next falling edge.
  task automatic tick(input logic c, input logic e_ir, e_av, e_bv);
    bit push_ok;
    #2;
    if (c) begin
      check("vec_in_ready", 32'(in_ready), 32'(e_ir));
      check("vec_a_valid", 32'(a_valid), 32'(e_av));
      check("vec_b_valid", 32'(b_valid), 32'(e_bv));
    end
    push_ok = 0;
    if (model_ok) begin
      push_ok = in_sel ? (qb.size() < DEPTH) : (qa.size() < DEPTH);
      check("in_ready", 32'(in_ready), 32'(push_ok));
      check("a_valid", 32'(a_valid), 32'(qa.size() != 0));
      check("b_valid", 32'(b_valid), 32'(qb.size() != 0));
      if (!a_valid) check("a_data_zero", a_data, '0);
      if (!b_valid) check("b_data_zero", b_data, '0);
`ifdef DEMUX_STATS_EN
      check("a_count", 32'(a_count), cnt_a);
      check("b_count", 32'(b_count), cnt_b);
`endif
      if (a_valid && a_ready && qa.size() != 0) begin
        check("a_data", a_data, qa.pop_front());
        if (!rst && cnt_a < 3) cnt_a++;
      end
      if (b_valid && b_ready && qb.size() != 0) begin
        check("b_data", b_data, qb.pop_front());
        if (!rst && cnt_b < 3) cnt_b++;
      end
    end
    if (rst) begin
      qa.delete();
      qb.delete();
      cnt_a = 0;
      cnt_b = 0;
      model_ok = 1;
    end else if (model_ok && in_valid && push_ok) begin
      if (in_sel) qb.push_back(in_data);
      else qa.push_back(in_data);
    end
    @(negedge clk);
  endtask

  initial begin
    //                 rst v  sel data          ar br  chk ir av bv
    tbl[0]  = mk(1, 1, 0, 32'h0000_0011, 1, 1, 0, 0, 0, 0);
    tbl[1]  = mk(1, 1, 0, 32'h0000_0012, 1, 1, 1, 1, 0, 0);
    tbl[2]  = mk(0, 1, 0, 32'hAAAA_AAAA, 1, 1, 1, 1, 0, 0);
    tbl[3]  = mk(0, 1, 1, 32'hBBBB_BBBB, 1, 1, 1, 1, 1, 0);
    tbl[4]  = mk(0, 0, 0, 32'h0,         1, 1, 1, 1, 0, 1);
    tbl[5]  = mk(0, 0, 0, 32'h0,         1, 1, 1, 1, 0, 0);
    tbl[6]  = mk(0, 1, 0, 32'hA1A1_0001, 0, 1, 1, 1, 0, 0);
    tbl[7]  = mk(0, 1, 0, 32'hA2A2_0002, 0, 1, 1, 1, 1, 0);
    tbl[8]  = mk(0, 1, 0, 32'hA3A3_0003, 0, 1, 1, 0, 1, 0);
    tbl[9]  = mk(0, 1, 1, 32'hB1B1_0001, 0, 1, 1, 1, 1, 0);
    tbl[10] = mk(0, 0, 0, 32'h0,         1, 1, 1, 0, 1, 1);
    tbl[11] = mk(0, 0, 0, 32'h0,         1, 1, 1, 1, 1, 0);
    tbl[12] = mk(0, 0, 0, 32'h0,         1, 1, 1, 1, 0, 0);
    tbl[13] = mk(0, 1, 0, 32'hC1C1_0001, 0, 1, 1, 1, 0, 0);
    tbl[14] = mk(0, 1, 0, 32'hC2C2_0002, 0, 1, 1, 1, 1, 0);
    tbl[15] = mk(0, 1, 0, 32'hC3C3_0003, 1, 1, 1, 0, 1, 0);
    tbl[16] = mk(0, 1, 0, 32'hC3C3_0003, 1, 1, 1, 1, 1, 0);
    tbl[17] = mk(0, 1, 0, 32'hC4C4_0004, 1, 1, 1, 1, 1, 0);
    tbl[18] = mk(0, 0, 0, 32'h0,         1, 1, 1, 1, 1, 0);
    tbl[19] = mk(0, 0, 0, 32'h0,         1, 1, 1, 1, 0, 0);
    tbl[20] = mk(0, 1, 0, 32'hD1D1_0001, 0, 0, 1, 1, 0, 0);
    tbl[21] = mk(0, 1, 0, 32'hD2D2_0002, 0, 0, 1, 1, 1, 0);
    tbl[22] = mk(0, 1, 1, 32'hE1E1_0001, 0, 0, 1, 1, 1, 0);
    tbl[23] = mk(1, 0, 0, 32'h0,         1, 1, 1, 0, 1, 1);
    tbl[24] = mk(0, 0, 0, 32'h0,         1, 1, 1, 1, 0, 0);
    tbl[25] = mk(0, 0, 0, 32'h0,         1, 1, 1, 1, 0, 0);

    drive(1, 0, 0, '0, 1, 1);
    @(negedge clk);

    for (int i = 0; i < NVEC; i++) begin
      drive(tbl[i].rst, tbl[i].v, tbl[i].sel, tbl[i].data, tbl[i].ar, tbl[i].br);
      tick(tbl[i].chk, tbl[i].ir, tbl[i].av, tbl[i].bv);
    end

`ifdef DEMUX_STATS_EN
    // Five pops on a with a 2-bit counter must saturate at 3.
    drive(1, 0, 0, '0, 1, 1);
    tick(0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 0, 32'hF000_0000 + 32'(i), 1, 1);
      tick(0, 0, 0, 0);
    end
    drive(0, 0, 0, '0, 1, 1);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    check("stats_a_sat", 32'(a_count), 32'd3);
    check("stats_b_zero", 32'(b_count), 32'd0);
`endif

    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom(), ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0));
      tick(0, 0, 0, 0);
    end

    drive(0, 0, 0, '0, 1, 1);
    for (int i = 0; i < 20 && (qa.size() != 0 || qb.size() != 0); i++) begin
      tick(0, 0, 0, 0);
    end
    check("drain_a_empty", 32'(qa.size()), 32'd0);
    check("drain_b_empty", 32'(qb.size()), 32'd0);
    tick(0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
